// File: rtl/ysyx_23060077_rd_arbiter.sv
// Two-master (IFU/LSU) read-channel arbiter in front of one AXI4 AR/R port.
// One transaction in flight; round-robin grant with a one-cycle holdoff for the requester just served.
`timescale 1ns/1ps
module ysyx_23060077_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_r_valid_i,
  input  logic [ADDR_WIDTH-1:0] ifu_r_addr_i,
  input  logic [7:0]            ifu_r_len_i,
  output logic                  ifu_r_ready_o,
  output logic [DATA_WIDTH-1:0] ifu_r_data_o,
  output logic                  ifu_r_last_o,
  input  logic                  lsu_r_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_r_addr_i,
  input  logic [7:0]            lsu_r_len_i,
  input  logic [2:0]            lsu_r_size_i,
  output logic                  lsu_r_ready_o,
  output logic [DATA_WIDTH-1:0] lsu_r_data_o,
  output logic                  lsu_r_last_o,
  output logic [1:0]            lsu_r_resp_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  output logic [ADDR_WIDTH-1:0] m_araddr_o,
  output logic [7:0]            m_arlen_o,
  output logic [2:0]            m_arsize_o,
  output logic [3:0]            m_arid_o,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  input  logic [1:0]            m_rresp_i,
  input  logic                  m_rlast_i
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;          // 0 = IFU, 1 = LSU
  logic                  last_owner_q, last_owner_d;
  logic                  holdoff_q, holdoff_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;

  logic ifu_elig, lsu_elig, grant_lsu;

  // The requester served last is masked for exactly one IDLE cycle.
  assign ifu_elig  = ifu_r_valid_i & ~(holdoff_q & ~last_owner_q);
  assign lsu_elig  = lsu_r_valid_i & ~(holdoff_q & last_owner_q);
  assign grant_lsu = lsu_elig & (~ifu_elig | ~last_owner_q);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    holdoff_d    = holdoff_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    case (state_q)
      IDLE: begin
        holdoff_d = 1'b0;
        if (ifu_elig | lsu_elig) begin
          owner_d  = grant_lsu;
          araddr_d = grant_lsu ? lsu_r_addr_i : ifu_r_addr_i;
          arlen_d  = grant_lsu ? lsu_r_len_i : ifu_r_len_i;
          arsize_d = grant_lsu ? lsu_r_size_i : 3'b010;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (m_arready_i) state_d = DATA;
      end
      DATA: begin
        if (m_rvalid_i & m_rlast_i) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          holdoff_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    arvalid_d = (state_d == ADDR);
    rready_d  = (state_d == DATA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b0;
      holdoff_q    <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      holdoff_q    <= holdoff_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
    end
  end

  assign m_arvalid_o = arvalid_q;
  assign m_araddr_o  = araddr_q;
  assign m_arlen_o   = arlen_q;
  assign m_arsize_o  = arsize_q;
  assign m_arid_o    = {3'b000, owner_q};
  assign m_rready_o  = rready_q;

  // R beats go straight through to the owner with no added latency.
  logic ifu_sel, lsu_sel;
  assign ifu_sel = rready_q & ~owner_q;
  assign lsu_sel = rready_q & owner_q;

  assign ifu_r_ready_o = ifu_sel & m_rvalid_i;
  assign ifu_r_data_o  = ifu_sel ? m_rdata_i : '0;
  assign ifu_r_last_o  = ifu_sel & m_rvalid_i & m_rlast_i;
  assign lsu_r_ready_o = lsu_sel & m_rvalid_i;
  assign lsu_r_data_o  = lsu_sel ? m_rdata_i : '0;
  assign lsu_r_last_o  = lsu_sel & m_rvalid_i & m_rlast_i;
  assign lsu_r_resp_o  = lsu_sel ? m_rresp_i : 2'b00;

endmodule

// File: tb/tb_ysyx_23060077_rd_arbiter.sv
// Randomized bench for the IFU/LSU read arbiter, checked every cycle against a transaction-level model,
// preceded by a few directed sequences with hand-computed expectations.
`timescale 1ns/1ps
module tb_ysyx_23060077_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_r_valid_i, lsu_r_valid_i;
  logic [31:0] ifu_r_addr_i, lsu_r_addr_i;
  logic [7:0]  ifu_r_len_i, lsu_r_len_i;
  logic [2:0]  lsu_r_size_i;
  logic        ifu_r_ready_o, ifu_r_last_o, lsu_r_ready_o, lsu_r_last_o;
  logic [31:0] ifu_r_data_o, lsu_r_data_o;
  logic [1:0]  lsu_r_resp_o;
  logic        m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o, m_rlast_i;
  logic [31:0] m_araddr_o, m_rdata_i;
  logic [7:0]  m_arlen_o;
  logic [2:0]  m_arsize_o;
  logic [3:0]  m_arid_o;
  logic [1:0]  m_rresp_i;

  ysyx_23060077_rd_arbiter dut (
    .clk(clk), .reset(reset),
    .ifu_r_valid_i(ifu_r_valid_i), .ifu_r_addr_i(ifu_r_addr_i), .ifu_r_len_i(ifu_r_len_i),
    .ifu_r_ready_o(ifu_r_ready_o), .ifu_r_data_o(ifu_r_data_o), .ifu_r_last_o(ifu_r_last_o),
    .lsu_r_valid_i(lsu_r_valid_i), .lsu_r_addr_i(lsu_r_addr_i), .lsu_r_len_i(lsu_r_len_i),
    .lsu_r_size_i(lsu_r_size_i), .lsu_r_ready_o(lsu_r_ready_o), .lsu_r_data_o(lsu_r_data_o),
    .lsu_r_last_o(lsu_r_last_o), .lsu_r_resp_o(lsu_r_resp_o),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_araddr_o(m_araddr_o),
    .m_arlen_o(m_arlen_o), .m_arsize_o(m_arsize_o), .m_arid_o(m_arid_o),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .m_rdata_i(m_rdata_i),
    .m_rresp_i(m_rresp_i), .m_rlast_i(m_rlast_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit run_chk = 0;

  // Transaction-level model: is a read in flight, has its address been accepted, who owns it.
  bit          txn_live, addr_wait, txn_owner, last_served, holdoff;
  bit          served_ifu, served_lsu;
  logic [31:0] t_addr;
  logic [7:0]  t_len;
  logic [2:0]  t_size;
  int          beats;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  task automatic model_step();
    bit ifu_ok, lsu_ok;
    served_ifu = 0;
    served_lsu = 0;
    if (reset) begin
      txn_live = 0; addr_wait = 0; txn_owner = 0; last_served = 0; holdoff = 0;
      t_addr = '0; t_len = '0; t_size = '0; beats = 0;
    end else if (!txn_live) begin
      ifu_ok  = ifu_r_valid_i && !(holdoff && last_served == 1'b0);
      lsu_ok  = lsu_r_valid_i && !(holdoff && last_served == 1'b1);
      holdoff = 0;
      if (ifu_ok || lsu_ok) begin
        txn_owner = (ifu_ok && lsu_ok) ? !last_served : lsu_ok;
        t_addr    = txn_owner ? lsu_r_addr_i : ifu_r_addr_i;
        t_len     = txn_owner ? lsu_r_len_i : ifu_r_len_i;
        t_size    = txn_owner ? lsu_r_size_i : 3'd2;
        txn_live  = 1; addr_wait = 1; beats = 0;
      end
    end else if (addr_wait) begin
      if (m_arready_i) addr_wait = 0;
    end else if (m_rvalid_i) begin
      if (m_rlast_i) begin
        txn_live = 0; last_served = txn_owner; holdoff = 1;
        if (txn_owner) served_lsu = 1; else served_ifu = 1;
      end else begin
        beats++;
      end
    end
  endtask

  task automatic compare();
    bit in_data, to_ifu, to_lsu;
    in_data = txn_live && !addr_wait;
    to_ifu  = in_data && !txn_owner;
    to_lsu  = in_data && txn_owner;
    chk("arvalid", m_arvalid_o, txn_live && addr_wait);
    chk("rready", m_rready_o, in_data);
    chk("araddr", m_araddr_o, t_addr);
    chk("arlen", m_arlen_o, t_len);
    chk("arsize", m_arsize_o, t_size);
    chk("arid", m_arid_o, {3'b0, txn_owner});
    chk("ifu_ready", ifu_r_ready_o, to_ifu && m_rvalid_i);
    chk("ifu_last", ifu_r_last_o, to_ifu && m_rvalid_i && m_rlast_i);
    chk("ifu_data", ifu_r_data_o, to_ifu ? m_rdata_i : 32'h0);
    chk("lsu_ready", lsu_r_ready_o, to_lsu && m_rvalid_i);
    chk("lsu_last", lsu_r_last_o, to_lsu && m_rvalid_i && m_rlast_i);
    chk("lsu_data", lsu_r_data_o, to_lsu ? m_rdata_i : 32'h0);
    chk("lsu_resp", lsu_r_resp_o, to_lsu ? m_rresp_i : 2'b0);
  endtask

  always @(negedge clk) if (run_chk) compare();

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_random();
    reset       = ($urandom_range(0, 299) == 0);
    m_arready_i = (txn_live && addr_wait) ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
    m_rvalid_i  = (txn_live && !addr_wait) ? ($urandom_range(0, 9) < 6) : 1'b0;
    m_rlast_i   = m_rvalid_i ? (beats == int'(t_len)) : 1'($urandom_range(0, 1));
    m_rdata_i   = $urandom;
    m_rresp_i   = 2'($urandom_range(0, 3));
    if (served_ifu || !ifu_r_valid_i) begin
      ifu_r_valid_i = served_ifu ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) < 4);
      ifu_r_addr_i  = $urandom;
      ifu_r_len_i   = 8'($urandom_range(0, 3));
    end else if ($urandom_range(0, 49) == 0) begin
      ifu_r_valid_i = 1'b0;
    end
    if (served_lsu || !lsu_r_valid_i) begin
      lsu_r_valid_i = served_lsu ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) < 4);
      lsu_r_addr_i  = $urandom;
      lsu_r_len_i   = 8'($urandom_range(0, 3));
      lsu_r_size_i  = 3'($urandom_range(0, 2));
    end else if ($urandom_range(0, 49) == 0) begin
      lsu_r_valid_i = 1'b0;
    end
  endtask

  initial begin
    reset = 1; ifu_r_valid_i = 0; lsu_r_valid_i = 0;
    ifu_r_addr_i = 0; ifu_r_len_i = 0; lsu_r_addr_i = 0; lsu_r_len_i = 0; lsu_r_size_i = 0;
    m_arready_i = 0; m_rvalid_i = 0; m_rlast_i = 0; m_rdata_i = 0; m_rresp_i = 0;
    adv(); adv();
    run_chk = 1;

    // Reset state.
    @(negedge clk);
    chk("rst_arvalid", m_arvalid_o, 1'b0);
    chk("rst_rready", m_rready_o, 1'b0);
    chk("rst_araddr", m_araddr_o, 32'h0);
    chk("rst_ifu_ready", ifu_r_ready_o, 1'b0);
    chk("rst_lsu_last", lsu_r_last_o, 1'b0);
    adv();

    // IFU-only single-beat read.
    reset = 0; ifu_r_valid_i = 1; ifu_r_addr_i = 32'h3000_0000; ifu_r_len_i = 0;
    @(negedge clk); adv();
    @(negedge clk);
    chk("d1_arvalid", m_arvalid_o, 1'b1);
    chk("d1_araddr", m_araddr_o, 32'h3000_0000);
    chk("d1_arlen", m_arlen_o, 8'd0);
    chk("d1_arsize", m_arsize_o, 3'd2);
    chk("d1_arid", m_arid_o, 4'd0);
    adv();
    m_arready_i = 1;
    @(negedge clk); adv();
    m_arready_i = 0;
    @(negedge clk); adv();
    m_rvalid_i = 1; m_rlast_i = 1; m_rdata_i = 32'h0000_0413;
    @(negedge clk);
    chk("d1_ifu_ready", ifu_r_ready_o, 1'b1);
    chk("d1_ifu_last", ifu_r_last_o, 1'b1);
    chk("d1_ifu_data", ifu_r_data_o, 32'h0000_0413);
    chk("d1_lsu_ready", lsu_r_ready_o, 1'b0);
    chk("d1_lsu_data", lsu_r_data_o, 32'h0);
    adv();
    m_rvalid_i = 0; m_rlast_i = 0; ifu_r_valid_i = 0;
    @(negedge clk);
    chk("d1_idle_arvalid", m_arvalid_o, 1'b0);
    adv();

    // Both valid out of reset: LSU first, IFU address two cycles after LSU's last beat.
    reset = 1;
    @(negedge clk); adv();
    reset = 0;
    ifu_r_valid_i = 1; ifu_r_addr_i = 32'h3000_0004; ifu_r_len_i = 0;
    lsu_r_valid_i = 1; lsu_r_addr_i = 32'h8000_0010; lsu_r_len_i = 0; lsu_r_size_i = 3'd0;
    @(negedge clk); adv();
    m_arready_i = 1;
    @(negedge clk);
    chk("d2_arid", m_arid_o, 4'd1);
    chk("d2_araddr", m_araddr_o, 32'h8000_0010);
    chk("d2_arsize", m_arsize_o, 3'd0);
    adv();
    m_arready_i = 0; m_rvalid_i = 1; m_rlast_i = 1; m_rdata_i = 32'h55; m_rresp_i = 2'd2;
    @(negedge clk);
    chk("d2_lsu_last", lsu_r_last_o, 1'b1);
    chk("d2_lsu_resp", lsu_r_resp_o, 2'd2);
    chk("d2_ifu_ready", ifu_r_ready_o, 1'b0);
    adv();
    m_rvalid_i = 0; m_rlast_i = 0;
    @(negedge clk);
    chk("d2_holdoff_arvalid", m_arvalid_o, 1'b0);
    adv();
    @(negedge clk);
    chk("d2_ifu_arvalid", m_arvalid_o, 1'b1);
    chk("d2_ifu_arid", m_arid_o, 4'd0);
    chk("d2_ifu_araddr", m_araddr_o, 32'h3000_0004);
    adv();

    // Randomized traffic, resets included.
    for (int i = 0; i < 4000; i++) begin
      drive_random();
      @(negedge clk);
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
